fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Controller that sequences the program counter and instruction-fetch port of the single-cycle/pipelined datapath. Drives the PC's `pc_wait` and `PCSrc` inputs and the instruction-memory read enable from instruction-memory handshake, hazard stalls, control-transfer redirects from execute, and halt. Holds a redirect that arrives while a fetch is still outstanding, so the fetch address never changes mid-request. Keeps fetch and stall performance counters.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ihit  in  1  instruction memory returns valid instruction this cycle.
- stall  in  1  hazard unit requests fetch hold.
- redirect_valid  in  1  execute resolved a taken branch/jump this cycle.
- redirect_src  in  2  PCSrc code for the redirect: SEL_LOAD_ADDR, SEL_LOAD_JR_ADDR or SEL_LOAD_IMM16.
- halt  in  1  halt instruction decoded.
- iren  out  1  instruction-memory read enable.
- pc_wait  out  1  to PC: hold current address.
- PCSrc  out  2  to PC: next-address select (data_path_muxs_pkg codes).
- flush  out  1  squash IF/ID contents at next edge.
- fetch_valid  out  1  fetched instruction accepted into decode this cycle.
- redirect_pending  out  1  a held redirect is waiting for ihit.
- halted  out  1  fetch permanently stopped.
- fetch_count  out  CNT_W  accepted instructions.
- stall_count  out  CNT_W  cycles with pc_wait=1 in FETCH or PENDING.

## Operation
- States: IDLE, FETCH, PENDING, HALTED. Register pend_src (2 bits).
- IDLE (reset state): iren=0, pc_wait=1, all pulses 0. Unconditionally -> FETCH next edge.
- FETCH: iren=1. Priority redirect > halt > stall > ihit:
  - redirect_valid & ihit: pc_wait=0, PCSrc=redirect_src, flush=1, fetch_valid=0; stay FETCH.
  - redirect_valid & !ihit: pc_wait=1, flush=1, pend_src<=redirect_src; -> PENDING.
  - halt (no redirect): pc_wait=1, fetch_valid=0; -> HALTED.
  - stall: pc_wait=1, fetch_valid=0.
  - ihit: pc_wait=0, PCSrc=SEL_LOAD_NXT_INSTR, fetch_valid=1.
  - otherwise pc_wait=1.
- PENDING: iren=1, redirect_pending=1, pc_wait=1 until ihit. On ihit: pc_wait=0, PCSrc=pend_src, flush=1, fetch_valid=0; -> FETCH. redirect_valid, halt and stall ignored in PENDING.
- HALTED: iren=0, pc_wait=1, halted=1; exits only by RST.
- PCSrc=SEL_LOAD_NXT_INSTR whenever not otherwise specified.
- Counters: fetch_count +1 on fetch_valid; stall_count +1 per cycle in FETCH/PENDING with pc_wait=1. Both saturate at 2^CNT_W-1, never wrap.

## Timing
- RST high (any time, mid-PENDING included): state IDLE, pend_src=SEL_LOAD_NXT_INSTR, counters 0, outputs iren=0, pc_wait=1, PCSrc=SEL_LOAD_NXT_INSTR, flush=0, fetch_valid=0, redirect_pending=0, halted=0.
- First edge after RST falls: IDLE->FETCH; iren=1 from that cycle.
- pc_wait, PCSrc, flush, fetch_valid are combinational (Mealy) from state and current inputs: zero-cycle path ihit->pc_wait; PC updates on the same edge.
- iren, redirect_pending, halted are decoded from state only (Moore).
- Redirect latency: applied at the edge of the redirect cycle if ihit, else at the edge of the first ihit cycle after; never earlier.
- Counters update at the edge ending the counted cycle.

## Test plan
- Reset then ihit=1 each cycle, no stall: cycle 0 IDLE (iren=0,pc_wait=1), then pc_wait=0, fetch_valid=1 every cycle; after 10 hits fetch_count=10, stall_count=1 excluded (IDLE not counted: stall_count=0).
- ihit=0 for 3 cycles then 1, redirect_valid=1 with SEL_LOAD_JR_ADDR on first miss cycle: PENDING 3 cycles, redirect_pending=1, pc_wait=1; on hit PCSrc=SEL_LOAD_JR_ADDR, pc_wait=0, flush=1; stall_count=3.
- redirect_valid=1 (SEL_LOAD_IMM16), halt=1, stall=1, ihit=1 same cycle: PCSrc=SEL_LOAD_IMM16, pc_wait=0, flush=1, state stays FETCH.
- halt=1 with ihit=1: next cycle halted=1, iren=0, pc_wait=1 held for 20 cycles regardless of inputs; counters frozen.
- RST pulse while in PENDING: outputs return to reset values immediately; after release, no stale redirect applied (first hit gives PCSrc=SEL_LOAD_NXT_INSTR).
- CNT_W=4, 20 consecutive hits: fetch_count saturates at 15.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives PC hold/select and instruction-memory read enable from
// imem handshake, hazard stalls, execute redirects and halt; keeps perf counters.
module fetch_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_src,
  input  logic             halt,
  output logic             iren,
  output logic             pc_wait,
  output logic [1:0]       PCSrc,
  output logic             flush,
  output logic             fetch_valid,
  output logic             redirect_pending,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count
);

  // PC next-address select codes (data_path_muxs_pkg encoding)
  localparam logic [1:0] SEL_LOAD_NXT_INSTR = 2'd0;
  localparam logic [1:0] SEL_LOAD_ADDR      = 2'd1;
  localparam logic [1:0] SEL_LOAD_JR_ADDR   = 2'd2;
  localparam logic [1:0] SEL_LOAD_IMM16     = 2'd3;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;
  localparam logic [1:0] HALTED  = 2'd3;

  logic [1:0] state_r;
  logic [1:0] next_state_s;
  logic [1:0] pend_src_r;
  logic [1:0] pend_src_nxt_s;
  logic       stall_cycle_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Next-state and Mealy outputs; a redirect without ihit is parked in pend_src
  always_comb begin
    next_state_s   = state_r;
    pend_src_nxt_s = pend_src_r;
    pc_wait        = 1'b1;
    PCSrc          = SEL_LOAD_NXT_INSTR;
    flush          = 1'b0;
    fetch_valid    = 1'b0;
    case (state_r)
      IDLE: begin
        next_state_s = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (ihit) begin
            pc_wait = 1'b0;
            PCSrc   = redirect_src;
          end else begin
            pend_src_nxt_s = redirect_src;
            next_state_s   = PENDING;
          end
        end else if (halt) begin
          next_state_s = HALTED;
        end else if (stall) begin
          pc_wait = 1'b1;
        end else if (ihit) begin
          pc_wait     = 1'b0;
          fetch_valid = 1'b1;
        end else begin
          pc_wait = 1'b1;
        end
      end
      PENDING: begin
        if (ihit) begin
          pc_wait      = 1'b0;
          PCSrc        = pend_src_r;
          flush        = 1'b1;
          next_state_s = FETCH;
        end else begin
          pc_wait = 1'b1;
        end
      end
      HALTED: begin
        next_state_s = HALTED;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  assign iren             = (state_r == FETCH) || (state_r == PENDING);
  assign redirect_pending = (state_r == PENDING);
  assign halted           = (state_r == HALTED);
  assign stall_cycle_s    = iren && pc_wait;

  // State and held redirect source
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= IDLE;
      pend_src_r <= SEL_LOAD_NXT_INSTR;
    end else begin
      state_r    <= next_state_s;
      pend_src_r <= pend_src_nxt_s;
    end
  end

  // Saturating performance counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_count <= {CNT_W{1'b0}};
      stall_count <= {CNT_W{1'b0}};
    end else begin
      if (fetch_valid) begin
        fetch_count <= sat_inc(fetch_count);
      end
      if (stall_cycle_s) begin
        stall_count <= sat_inc(stall_count);
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random traffic
// against a behavioural model; a CNT_W=4 copy shares the inputs to exercise saturation.
module tb_fetch_sequencer;

  localparam logic [1:0] SEL_NXT  = 2'd0;
  localparam logic [1:0] SEL_ADDR = 2'd1;
  localparam logic [1:0] SEL_JR   = 2'd2;
  localparam logic [1:0] SEL_IMM  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0, stall = 1'b0, redirect_valid = 1'b0, halt = 1'b0;
  logic [1:0]  redirect_src = SEL_NXT;

  logic        iren, pc_wait, flush, fetch_valid, redirect_pending, halted;
  logic [1:0]  PCSrc;
  logic [31:0] fetch_count, stall_count;
  logic        iren4, pc_wait4, flush4, fetch_valid4, redirect_pending4, halted4;
  logic [1:0]  PCSrc4;
  logic [3:0]  fetch_count4, stall_count4;

  fetch_sequencer #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_src(redirect_src), .halt(halt), .iren(iren), .pc_wait(pc_wait), .PCSrc(PCSrc),
    .flush(flush), .fetch_valid(fetch_valid), .redirect_pending(redirect_pending),
    .halted(halted), .fetch_count(fetch_count), .stall_count(stall_count));

  fetch_sequencer #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_src(redirect_src), .halt(halt), .iren(iren4), .pc_wait(pc_wait4), .PCSrc(PCSrc4),
    .flush(flush4), .fetch_valid(fetch_valid4), .redirect_pending(redirect_pending4),
    .halted(halted4), .fetch_count(fetch_count4), .stall_count(stall_count4));

  always #5 CLK = ~CLK;

  typedef enum {M_IDLE, M_FETCH, M_PEND, M_HALT} mstate_t;
  mstate_t    ms;
  logic [1:0] mpend;
  longint     fc, sc;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat15(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic cmp_all(input bit ei, input bit ew, input logic [1:0] es, input bit ef,
                         input bit efv, input bit erp, input bit eh);
    check("iren", iren, ei);
    check("pc_wait", pc_wait, ew);
    check("PCSrc", PCSrc, es);
    check("flush", flush, ef);
    check("fetch_valid", fetch_valid, efv);
    check("redirect_pending", redirect_pending, erp);
    check("halted", halted, eh);
    check("fetch_count", fetch_count, fc);
    check("stall_count", stall_count, sc);
    check("fetch_count4", fetch_count4, sat15(fc));
    check("stall_count4", stall_count4, sat15(sc));
    check("pc_wait4", pc_wait4, ew);
  endtask

  // Apply current inputs for one cycle: predict, compare at negedge, advance model at posedge
  task automatic step();
    bit ei, ew, ef, efv, erp, eh;
    logic [1:0] es, npend;
    mstate_t nx;
    es = SEL_NXT; ew = 1'b1; ef = 1'b0; efv = 1'b0; nx = ms; npend = mpend;
    ei  = (ms == M_FETCH) || (ms == M_PEND);
    erp = (ms == M_PEND);
    eh  = (ms == M_HALT);
    case (ms)
      M_IDLE: nx = M_FETCH;
      M_FETCH: begin
        if (redirect_valid) begin
          ef = 1'b1;
          if (ihit) begin ew = 1'b0; es = redirect_src; end
          else begin npend = redirect_src; nx = M_PEND; end
        end else if (halt) nx = M_HALT;
        else if (!stall && ihit) begin ew = 1'b0; efv = 1'b1; end
      end
      M_PEND: if (ihit) begin ew = 1'b0; es = mpend; ef = 1'b1; nx = M_FETCH; end
      default: ;
    endcase
    @(negedge CLK);
    cmp_all(ei, ew, es, ef, efv, erp, eh);
    if (efv) fc++;
    if (ew && ei) sc++;
    ms = nx;
    mpend = npend;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    ms = M_IDLE; mpend = SEL_NXT; fc = 0; sc = 0;
    #1;
    cmp_all(1'b0, 1'b1, SEL_NXT, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic set_in(input bit h, input bit s, input bit rv, input logic [1:0] rs, input bit hl);
    ihit = h; stall = s; redirect_valid = rv; redirect_src = rs; halt = hl;
  endtask

  initial begin
    longint sc0;
    int hcnt;
    #2;
    do_reset();

    // Streaming hits: 10 then 20 total for CNT_W=4 saturation
    set_in(1, 0, 0, SEL_NXT, 0);
    for (int i = 0; i < 11; i++) step();
    check("fetch_count_10", fetch_count, 64'd10);
    check("stall_count_0", stall_count, 64'd0);
    for (int i = 0; i < 10; i++) step();
    check("fetch_count4_sat", fetch_count4, 64'd15);

    // Redirect on first miss, held across misses, applied on hit
    sc0 = sc;
    set_in(0, 0, 1, SEL_JR, 0);
    step();
    set_in(0, 1, 1, SEL_ADDR, 1);
    step();
    step();
    set_in(1, 0, 0, SEL_NXT, 0);
    check("pend_state", redirect_pending, 64'd1);
    step();
    check("pend_stall_count", stall_count, sc0 + 3);

    // Redirect outranks halt and stall in the same cycle
    set_in(1, 1, 1, SEL_IMM, 1);
    step();
    set_in(1, 0, 0, SEL_NXT, 0);
    step();

    // Reset while PENDING: no stale redirect afterwards
    set_in(0, 0, 1, SEL_IMM, 0);
    step();
    step();
    do_reset();
    set_in(1, 0, 0, SEL_NXT, 0);
    step();
    step();

    // Halt with ihit, then 20 cycles of arbitrary inputs
    set_in(1, 0, 0, SEL_NXT, 1);
    step();
    for (int i = 0; i < 20; i++) begin
      set_in($urandom % 2, $urandom % 2, $urandom % 2, 2'($urandom_range(1, 3)), $urandom % 2);
      step();
    end

    // Random traffic with occasional resets
    do_reset();
    hcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 6) == 0,
             2'($urandom_range(1, 3)), ($urandom % 80) == 0);
      if (ms == M_HALT) hcnt++;
      if (hcnt > 6 || ($urandom % 400) == 0) begin
        hcnt = 0;
        do_reset();
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
